boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader_pkg.sv | 17 +
 rtl/boot_loader_if.sv | 30 +++
 rtl/boot_checksum.sv | 27 ++
 rtl/boot_loader.sv | 122 ++++++++++++
 tb/tb_boot_loader.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and default widths,
// reused by the chipset integration and the bench.
package boot_loader_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

endpackage

// File: rtl/boot_loader_if.sv
// ROM read port and RAM write port of the boot loader, grouped as one bus.
interface boot_loader_if
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    // ROM: rom_data is valid exactly one cycle after rom_rd.
    // RAM: a write is accepted in any cycle where ram_wr and ram_ready are both 1;
    //      until then ram_wr, ram_addr and ram_wdata are held stable.
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ready;

    modport master (
        output rom_rd, rom_addr, ram_wr, ram_addr, ram_wdata,
        input  rom_data, ram_ready
    );

    modport slave (
        input  rom_rd, rom_addr, ram_wr, ram_addr, ram_wdata,
        output rom_data, ram_ready
    );

endinterface

// File: rtl/boot_checksum.sv
// Modulo-2^DATA_W running sum of the copied payload words; cleared when a copy starts.
module boot_checksum #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_acc,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_sum
);

    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_acc) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/boot_loader.sv
// Copies COPY_WORDS words from boot ROM to RAM, then flags that the CPU may execute
// from RAM. Optional checksum of the image when BOOT_LOADER_CHECKSUM_EN is defined.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                COPY_WORDS = 256,
    parameter logic [ADDR_W-1:0] ROM_BASE   = '0,
    parameter logic [ADDR_W-1:0] RAM_BASE   = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    boot_loader_if.master bus,
    output logic          busy,
    output logic          flag_execute_from_ram,
    output logic          error,
    output state_t        dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(COPY_WORDS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_index;
    logic [DATA_W-1:0] r_data;
    logic              r_flag;
    logic              w_load;
    logic              w_accept;
    logic              w_last;
    logic              w_sum_ok;

    assign w_load   = (r_state == ST_IDLE) && start;
    assign w_accept = (r_state == ST_WRITE) && bus.ram_ready;
    assign w_last   = (r_index == LAST_IDX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_READ;
            ST_READ:    w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_WRITE;
            ST_WRITE: begin
                if (w_accept) begin
                    if (!w_last)       w_next = ST_READ;
                    else if (w_sum_ok) w_next = ST_DONE;
                    else               w_next = ST_ERROR;
                end
            end
            ST_DONE:    w_next = ST_DONE;
            ST_ERROR:   w_next = ST_ERROR;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_data  <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_index <= '0;
            end else if (w_accept && !w_last) begin
                r_index <= r_index + 1'b1;
            end
            if (r_state == ST_CAPTURE) begin
                r_data <= bus.rom_data;
            end
            // Terminal flags are registered off the state, giving one settle cycle after the last write.
            r_flag <= (r_state == ST_DONE);
        end
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] w_sum;
    logic              r_error;

    // The final word is the checksum of all preceding words, so it is not accumulated.
    boot_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_load),
        .i_acc  (w_accept && !w_last),
        .i_data (r_data),
        .o_sum  (w_sum)
    );

    assign w_sum_ok = (w_sum == r_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error <= 1'b0;
        end else begin
            r_error <= (r_state == ST_ERROR);
        end
    end

    assign error = r_error;
`else
    assign w_sum_ok = 1'b1;
    assign error    = 1'b0;
`endif

    // Address and data lines read as zero outside their strobe cycles.
    assign bus.rom_rd    = (r_state == ST_READ);
    assign bus.rom_addr  = bus.rom_rd ? (ROM_BASE + r_index) : '0;
    assign bus.ram_wr    = (r_state == ST_WRITE);
    assign bus.ram_addr  = bus.ram_wr ? (RAM_BASE + r_index) : '0;
    assign bus.ram_wdata = bus.ram_wr ? r_data : '0;

    assign busy                  = (r_state == ST_READ) || (r_state == ST_CAPTURE) ||
                                   (r_state == ST_WRITE);
    assign flag_execute_from_ram = r_flag;
    assign dbg_state             = r_state;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: 4-word copy from a ROM window wrapping at FFFE.
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam logic [15:0] ROM_B = 16'hFFFE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       flag;
  logic       error;
  state_t     dbg_state;
  logic       tb_ram_ready = 1'b1;
  logic [7:0] rom_img [4];
  logic [7:0] ram_mem [4];
  logic [15:0] rd_addr_q [$];
  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic [7:0]  exp_q [$];
  logic [15:0] rom_off;
  int n_checks = 0;
  int n_fail = 0;
  int both_seen = 0;
  int stall_left = 0;
  int cyc;
  int bcyc;

  boot_loader_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  boot_loader #(
    .ADDR_W(16), .DATA_W(8), .COPY_WORDS(4), .ROM_BASE(ROM_B), .RAM_BASE(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus), .busy(busy),
    .flag_execute_from_ram(flag), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign bus.ram_ready = tb_ram_ready;
  assign rom_off = bus.rom_addr - ROM_B;

  // ROM model: one-cycle read latency
  always @(posedge clk) begin
    if (bus.rom_rd) bus.rom_data <= rom_img[rom_off[1:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rd_addr_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < 4; i++) ram_mem[i] = 8'h00;
  endtask

  task automatic apply_reset();
    tb_ram_ready = 1'b1;
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after each rising edge: decides ram_ready and logs bus activity.
  task automatic observe_cycle();
    tb_ram_ready = 1'b1;
    if (stall_left > 0 && dbg_state == ST_WRITE && wr_addr_q.size() == 2) begin
      tb_ram_ready = 1'b0;
      stall_left--;
      check_eq("stall_wr", {31'd0, bus.ram_wr}, 1);
      check_eq("stall_addr", {16'd0, bus.ram_addr}, 2);
      check_eq("stall_data", {24'd0, bus.ram_wdata}, 33);
    end
    if (bus.rom_rd && bus.ram_wr) both_seen++;
    if (bus.rom_rd) rd_addr_q.push_back(bus.rom_addr);
    if (bus.ram_wr && tb_ram_ready) begin
      ram_mem[bus.ram_addr[1:0]] = bus.ram_wdata;
      wr_addr_q.push_back(bus.ram_addr);
      wr_data_q.push_back(bus.ram_wdata);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int max, output int c, output int b);
    c = 0;
    b = 0;
    while (c < max) begin
      observe_cycle();
      if (flag || error) break;
      if (busy) b++;
      step();
      c++;
    end
    check_eq("done_seen", {31'd0, flag | error}, 1);
  endtask

  task automatic check_image(input string tag);
    check_eq({tag, "_nwr"}, wr_addr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
      check_eq($sformatf("%s_waddr%0d", tag, i), {16'd0, wr_addr_q[i]}, i);
      check_eq($sformatf("%s_wdata%0d", tag, i), {24'd0, wr_data_q[i]}, {24'd0, exp_q[i]});
      check_eq($sformatf("%s_ram%0d", tag, i), {24'd0, ram_mem[i]}, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    rom_img = '{8'd11, 8'd22, 8'd33, 8'd44};
    exp_q = '{8'd11, 8'd22, 8'd33, 8'd44};
    bus.rom_data = 8'h00;

    // Reset state
    apply_reset();
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_flag", {31'd0, flag}, 0);
    check_eq("rst_error", {31'd0, error}, 0);
    check_eq("rst_rom_rd", {31'd0, bus.rom_rd}, 0);
    check_eq("rst_rom_addr", {16'd0, bus.rom_addr}, 0);
    check_eq("rst_ram_wr", {31'd0, bus.ram_wr}, 0);
    check_eq("rst_ram_addr", {16'd0, bus.ram_addr}, 0);
    check_eq("rst_state", {29'd0, dbg_state}, 0);

    // Basic copy, ROM window wraps FFFE..0001
    do_start();
    run_until_done(100, cyc, bcyc);
    check_eq("t1_latency", cyc, 13);
    check_eq("t1_busy_cycles", bcyc, 12);
    check_eq("t1_error", {31'd0, error}, 0);
    check_image("t1");
    check_eq("t1_nrd", rd_addr_q.size(), 4);
    if (rd_addr_q.size() == 4) begin
      check_eq("t1_raddr0", {16'd0, rd_addr_q[0]}, 32'h0000FFFE);
      check_eq("t1_raddr1", {16'd0, rd_addr_q[1]}, 32'h0000FFFF);
      check_eq("t1_raddr2", {16'd0, rd_addr_q[2]}, 32'h00000000);
      check_eq("t1_raddr3", {16'd0, rd_addr_q[3]}, 32'h00000001);
    end
    repeat (5) begin
      observe_cycle();
      step();
    end
    check_eq("t1_flag_hold", {31'd0, flag}, 1);
    check_eq("t1_busy_done", {31'd0, busy}, 0);
    check_eq("t1_state_done", {29'd0, dbg_state}, {29'd0, ST_DONE});

    // Five-cycle RAM stall on word 2
    apply_reset();
    stall_left = 5;
    do_start();
    run_until_done(100, cyc, bcyc);
    check_eq("t2_latency", cyc, 18);
    check_eq("t2_stall_used", stall_left, 0);
    check_image("t2");

    // Asynchronous reset during the write of word 2, then a clean restart
    apply_reset();
    do_start();
    for (int i = 0; i < 20; i++) begin
      observe_cycle();
      if (dbg_state == ST_WRITE && wr_addr_q.size() == 3) break;
      step();
    end
    check_eq("t3_in_write2", {16'd0, bus.ram_addr}, 2);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t3_rst_ram_wr", {31'd0, bus.ram_wr}, 0);
    check_eq("t3_rst_ram_addr", {16'd0, bus.ram_addr}, 0);
    check_eq("t3_rst_ram_wdata", {24'd0, bus.ram_wdata}, 0);
    check_eq("t3_rst_rom_rd", {31'd0, bus.rom_rd}, 0);
    check_eq("t3_rst_busy", {31'd0, busy}, 0);
    check_eq("t3_rst_flag", {31'd0, flag}, 0);
    check_eq("t3_rst_state", {29'd0, dbg_state}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    do_start();
    run_until_done(100, cyc, bcyc);
    check_eq("t3_latency", cyc, 13);
    check_image("t3");

    // start held high for 100 cycles: exactly one copy
    apply_reset();
    @(negedge clk);
    start = 1'b1;
    step();
    for (int i = 0; i < 100; i++) begin
      observe_cycle();
      step();
    end
    start = 1'b0;
    check_image("t4");
    check_eq("t4_flag", {31'd0, flag}, 1);
    check_eq("t4_busy", {31'd0, busy}, 0);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Checksum good: 1+2+3 = 6
    rom_img = '{8'd1, 8'd2, 8'd3, 8'd6};
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd6};
    apply_reset();
    do_start();
    run_until_done(100, cyc, bcyc);
    check_eq("ck_ok_latency", cyc, 13);
    check_eq("ck_ok_flag", {31'd0, flag}, 1);
    check_eq("ck_ok_error", {31'd0, error}, 0);
    check_image("ck_ok");

    // Checksum bad: 1+2+3 != 7
    rom_img = '{8'd1, 8'd2, 8'd3, 8'd7};
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd7};
    apply_reset();
    do_start();
    run_until_done(100, cyc, bcyc);
    check_eq("ck_bad_latency", cyc, 13);
    check_eq("ck_bad_error", {31'd0, error}, 1);
    check_eq("ck_bad_flag", {31'd0, flag}, 0);
    check_eq("ck_bad_busy", {31'd0, busy}, 0);
    check_image("ck_bad");
    repeat (3) step();
    check_eq("ck_bad_hold", {31'd0, error}, 1);
`endif

    check_eq("rd_wr_exclusive", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
